// File: rtl/adder_pkg.sv
// Shared definitions for the adder_pipe block.
// Contents: MODE encodings, plus helpers for the two's-complement
// overflow rules used by the arithmetic core.
package adder_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;  // A + B
  localparam logic [1:0] MODE_SUB = 2'b01;  // A - B
  localparam logic [1:0] MODE_ACC = 2'b10;  // ACC + A
  localparam logic [1:0] MODE_CLR = 2'b11;  // ACC <- 0

  // Signed overflow of x + y.
  // Both operands have the same sign, but the result's sign differs from it.
  function automatic logic add_ovf(input logic xs, input logic ys, input logic rs);
    return (xs == ys) && (rs != xs);
  endfunction

  // Signed overflow of x - y.
  // The operands have different signs, and the result's sign differs from x.
  function automatic logic sub_ovf(input logic xs, input logic ys, input logic rs);
    return (xs != ys) && (rs != xs);
  endfunction

endpackage

// File: rtl/adder_pipe_addsub_core.sv
// addsub_core: purely combinational add/sub/acc/clear datapath.
// Ports:
//   MODE   in   2      operation select (adder_pkg MODE_*)
//   X, Y   in   WIDTH  operands (for accumulate, X = ACC and Y = A)
//   SUM    out  WIDTH  result; clamped when SATURATE=1 and carry/borrow is set
//   CARRY  out  1      raw unsigned carry-out (add/acc) or borrow (sub)
//   OVF    out  1      raw two's-complement overflow
// In clear mode, SUM, CARRY and OVF are all zero.
module addsub_core
  import adder_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY,
  output logic             OVF
);

  logic [WIDTH:0] add_s;
  logic [WIDTH:0] sub_s;

  // The extra top bit carries out the carry (add) or the borrow (sub).
  // For the subtract, that bit is 1 exactly when X < Y.
  assign add_s = {1'b0, X} + {1'b0, Y};
  assign sub_s = {1'b0, X} - {1'b0, Y};

  // Select the result and flags by MODE.
  // Saturation changes only SUM; the flags always describe the raw result.
  always_comb begin
    SUM   = {WIDTH{1'b0}};
    CARRY = 1'b0;
    OVF   = 1'b0;
    case (MODE)
      MODE_ADD, MODE_ACC: begin
        CARRY = add_s[WIDTH];
        OVF   = add_ovf(X[WIDTH-1], Y[WIDTH-1], add_s[WIDTH-1]);
        SUM   = (SATURATE && add_s[WIDTH]) ? {WIDTH{1'b1}} : add_s[WIDTH-1:0];
      end
      MODE_SUB: begin
        CARRY = sub_s[WIDTH];
        OVF   = sub_ovf(X[WIDTH-1], Y[WIDTH-1], sub_s[WIDTH-1]);
        SUM   = (SATURATE && sub_s[WIDTH]) ? {WIDTH{1'b0}} : sub_s[WIDTH-1:0];
      end
      MODE_CLR: begin
        SUM   = {WIDTH{1'b0}};
        CARRY = 1'b0;
        OVF   = 1'b0;
      end
      default: begin
        SUM   = {WIDTH{1'b0}};
        CARRY = 1'b0;
        OVF   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: a two-stage, flow-controlled arithmetic stage.
// Operations: add, subtract, accumulate and clear.
// Ports:
//   CLK        in   1      clock, rising edge
//   RST        in   1      synchronous active-high reset
//   IN_VALID   in   1      A, B and MODE are valid
//   IN_READY   out  1      stage 1 can accept this cycle (0 while RST is high)
//   A, B       in   WIDTH  operands
//   MODE       in   2      00 add, 01 sub, 10 accumulate, 11 clear ACC
//   OUT_VALID  out  1      SUM, CARRY and OVF are valid
//   OUT_READY  in   1      downstream accepts this cycle
//   SUM        out  WIDTH  result
//   CARRY      out  1      carry (add/acc) or borrow (sub)
//   OVF        out  1      signed overflow of the unwrapped result
// Stage 1 registers the operands.
// Arithmetic is evaluated on the stage-1 contents as they move to stage 2,
// which is the output register. There is therefore no combinational path
// from A or B to SUM.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY,
  output logic             OVF
);

  // Stage 1: input register
  logic             s1_valid_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       mode_r;

  // Stage 2: output register
  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             ovf_r;

  logic [WIDTH-1:0] acc_r;

  logic             adv2_s;
  logic             xfer_s;
  logic             accept_s;
  logic             in_ready_s;
  logic [WIDTH-1:0] x_s;
  logic [WIDTH-1:0] y_s;
  logic [WIDTH-1:0] core_sum_s;
  logic             core_carry_s;
  logic             core_ovf_s;

  // Handshake decode.
  // Stage 2 can take new data when it is empty, or when it is being drained
  // this cycle. Stage 1 can take new data when it is empty, or when its
  // contents are moving on this cycle.
  assign adv2_s     = !out_valid_r || OUT_READY;
  assign xfer_s     = s1_valid_r && adv2_s;
  assign in_ready_s = !RST && (!s1_valid_r || adv2_s);
  assign accept_s   = IN_VALID && in_ready_s;

  // Accumulate adds A to ACC. Every other mode works on A and B.
  assign x_s = (mode_r == MODE_ACC) ? acc_r : a_r;
  assign y_s = (mode_r == MODE_ACC) ? a_r   : b_r;

  addsub_core #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_core (
    .MODE  (mode_r),
    .X     (x_s),
    .Y     (y_s),
    .SUM   (core_sum_s),
    .CARRY (core_carry_s),
    .OVF   (core_ovf_s)
  );

  // Stage 1: load on accept.
  // The stage empties when its contents move on and nothing replaces them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_r <= 1'b0;
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      mode_r     <= MODE_ADD;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      a_r        <= A;
      b_r        <= B;
      mode_r     <= MODE;
    end else if (adv2_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: capture the core result on transfer.
  // The result and flags are held while stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_r <= 1'b0;
      sum_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (adv2_s) begin
      out_valid_r <= s1_valid_r;
      if (xfer_s) begin
        sum_r   <= core_sum_s;
        carry_r <= core_carry_s;
        ovf_r   <= core_ovf_s;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Accumulator update.
  // ACC changes on the same edge that the op reaches stage 2, so the next
  // accumulate in stage 1 already sees the new value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (xfer_s && (mode_r == MODE_ACC)) begin
      acc_r <= core_sum_s;
    end else if (xfer_s && (mode_r == MODE_CLR)) begin
      acc_r <= {WIDTH{1'b0}};
    end else begin
      acc_r <= acc_r;
    end
  end

  assign IN_READY  = in_ready_s;
  assign OUT_VALID = out_valid_r;
  assign SUM       = sum_r;
  assign CARRY     = carry_r;
  assign OVF       = ovf_r;

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe.
// Three instances share the clock, reset and handshake:
//   u_dut  WIDTH=8,  SATURATE=0
//   u_sat  WIDTH=8,  SATURATE=1
//   u_w16  WIDTH=16, SATURATE=0
// Inputs are driven and outputs sampled on the falling edge, away from the
// active rising edge.
module tb_adder_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] a16;
  logic [15:0] b16;
  logic [1:0]  mode;
  logic        out_ready;

  logic        in_ready,  out_valid,  carry,  ovf;
  logic [7:0]  sum;
  logic        in_ready_s8,  out_valid_s8,  carry_s8,  ovf_s8;
  logic [7:0]  sum_s8;
  logic        in_ready_w,  out_valid_w,  carry_w,  ovf_w;
  logic [15:0] sum_w;

  int errors = 0;
  int checks = 0;

  adder_pipe #(.WIDTH(8), .SATURATE(1'b0)) u_dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a), .B(b), .MODE(mode), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .SUM(sum), .CARRY(carry), .OVF(ovf)
  );

  adder_pipe #(.WIDTH(8), .SATURATE(1'b1)) u_sat (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready_s8),
    .A(a), .B(b), .MODE(mode), .OUT_VALID(out_valid_s8), .OUT_READY(out_ready),
    .SUM(sum_s8), .CARRY(carry_s8), .OVF(ovf_s8)
  );

  adder_pipe #(.WIDTH(16), .SATURATE(1'b0)) u_w16 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready_w),
    .A(a16), .B(b16), .MODE(mode), .OUT_VALID(out_valid_w), .OUT_READY(out_ready),
    .SUM(sum_w), .CARRY(carry_w), .OVF(ovf_w)
  );

  // 25 MHz clock
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // Single op with OUT_READY high.
  // Called at a falling edge; returns at the falling edge just after the
  // result has reached stage 2.
  task automatic op(input logic [1:0] m, input logic [7:0] a8, input logic [7:0] b8,
                    input logic [15:0] aw, input logic [15:0] bw);
    int n;
    mode = m; a = a8; b = b8; a16 = aw; b16 = bw;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 8) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL op_accept: in_ready=%0b required 1 (timeout)", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'b00; a = 8'd0; b = 8'd0; a16 = 16'd0; b16 = 16'd0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++;
    if (sum !== 8'd0 || carry !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: sum=%0d c=%0b o=%0b want 0/0/0", sum, carry, ovf);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_add();
    op(2'b00, 8'd200, 8'd100, 16'hFFFF, 16'h0001);
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'd44 || carry !== 1'b1 || ovf !== 1'b0) begin
      errors++; $display("FAIL add_200_100: v=%0b sum=%0d c=%0b o=%0b want 1/44/1/0", out_valid, sum, carry, ovf);
    end
    checks++;
    if (sum_s8 !== 8'd255 || carry_s8 !== 1'b1 || ovf_s8 !== 1'b0) begin
      errors++; $display("FAIL add_sat: sum=%0d c=%0b o=%0b want 255/1/0", sum_s8, carry_s8, ovf_s8);
    end
    checks++;
    if (sum_w !== 16'h0000 || carry_w !== 1'b1 || ovf_w !== 1'b0) begin
      errors++; $display("FAIL add16_ffff_1: sum=%h c=%0b o=%0b want 0000/1/0", sum_w, carry_w, ovf_w);
    end
    op(2'b00, 8'd100, 8'd100, 16'h7FFF, 16'h0001);
    checks++;
    if (sum !== 8'd200 || carry !== 1'b0 || ovf !== 1'b1) begin
      errors++; $display("FAIL add_100_100: sum=%0d c=%0b o=%0b want 200/0/1", sum, carry, ovf);
    end
    checks++;
    if (sum_s8 !== 8'd200 || carry_s8 !== 1'b0) begin
      errors++; $display("FAIL add_sat_nocarry: sum=%0d c=%0b want 200/0", sum_s8, carry_s8);
    end
    checks++;
    if (sum_w !== 16'h8000 || carry_w !== 1'b0 || ovf_w !== 1'b1) begin
      errors++; $display("FAIL add16_7fff_1: sum=%h c=%0b o=%0b want 8000/0/1", sum_w, carry_w, ovf_w);
    end
  endtask

  task automatic test_sub();
    op(2'b01, 8'd5, 8'd10, 16'd5, 16'd10);
    checks++;
    if (sum !== 8'd251 || carry !== 1'b1 || ovf !== 1'b0) begin
      errors++; $display("FAIL sub_5_10: sum=%0d c=%0b o=%0b want 251/1/0", sum, carry, ovf);
    end
    checks++;
    if (sum_s8 !== 8'd0 || carry_s8 !== 1'b1) begin
      errors++; $display("FAIL sub_sat: sum=%0d c=%0b want 0/1", sum_s8, carry_s8);
    end
    checks++;
    if (sum_w !== 16'hFFFB || carry_w !== 1'b1) begin
      errors++; $display("FAIL sub16_5_10: sum=%h c=%0b want fffb/1", sum_w, carry_w);
    end
  endtask

  // Clear, then accumulate 10, 20, 30 back to back.
  // The results 0, 10, 30, 60 appear on four consecutive cycles.
  task automatic test_accumulate();
    logic [1:0] modes [4];
    logic [7:0] vals  [4];
    logic [7:0] exp_s [4];
    modes[0] = 2'b11; vals[0] = 8'd0;  exp_s[0] = 8'd0;
    modes[1] = 2'b10; vals[1] = 8'd10; exp_s[1] = 8'd10;
    modes[2] = 2'b10; vals[2] = 8'd20; exp_s[2] = 8'd30;
    modes[3] = 2'b10; vals[3] = 8'd30; exp_s[3] = 8'd60;
    out_ready = 1'b1; b = 8'd0; a16 = 16'd0; b16 = 16'd0;
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || sum !== exp_s[i-2] || carry !== 1'b0) begin
          errors++;
          $display("FAIL acc_step%0d: v=%0b sum=%0d c=%0b want 1/%0d/0", i-2, out_valid, sum, carry, exp_s[i-2]);
        end
      end
      if (i < 4) begin
        in_valid = 1'b1; mode = modes[i]; a = vals[i];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  // Four adds with OUT_READY low for three cycles.
  // The results must then come out as 2, 4, 6, 8.
  task automatic test_stall();
    logic [7:0] got [$];
    int  k;
    logic acc_now;
    k = 0;
    mode = 2'b00; a16 = 16'd0; b16 = 16'd0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = !(cyc >= 1 && cyc <= 3);
      in_valid  = (k < 4);
      a = 8'(k + 1); b = 8'(k + 1);
      #1;
      if (cyc == 2 || cyc == 3) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== 8'd2) begin
          errors++;
          $display("FAIL stall_hold_c%0d: in_ready=%0b v=%0b sum=%0d want 0/1/2", cyc, in_ready, out_valid, sum);
        end
      end
      if (out_valid && out_ready) got.push_back(sum);
      acc_now = in_valid && in_ready;
      @(negedge clk);
      if (acc_now) k++;
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() !== 4) begin
      errors++; $display("FAIL stall_count: got %0d results want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== 8'(2 * (i + 1))) begin
          errors++; $display("FAIL stall_order%0d: got %0d want %0d", i, got[i], 2 * (i + 1));
        end
      end
    end
  endtask

  // Reset with both stages full and ACC=60 (left by test_accumulate).
  // Afterwards, accumulate 5 must give 5.
  task automatic test_reset_midstream();
    out_ready = 1'b0; mode = 2'b00; in_valid = 1'b1;
    a = 8'd7; b = 8'd7;
    @(negedge clk);
    a = 8'd9; b = 8'd9;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL pre_reset_full: v=%0b in_ready=%0b want 1/0", out_valid, in_ready);
    end
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || sum !== 8'd0 || carry !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midstream_reset: v=%0b sum=%0d c=%0b in_ready=%0b want 0/0/0/0", out_valid, sum, carry, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_empty: v=%0b want 0", out_valid);
    end
    op(2'b10, 8'd5, 8'd0, 16'd5, 16'd0);
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'd5 || carry !== 1'b0) begin
      errors++; $display("FAIL acc_after_reset: v=%0b sum=%0d c=%0b want 1/5/0", out_valid, sum, carry);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_accumulate();
    test_stall();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
